// File: rtl/mem_sram_ctrl.sv
// mem_sram_ctrl: MEM-stage bridge between a 32-bit CPU load/store port and a
// 16-bit asynchronous SRAM. Each access is split into a low half-word phase
// (LO) and a high half-word phase (HI) of WAIT_CYCLES clocks each. The pipeline
// is stalled through ready=0 until the one-cycle DONE state.
module mem_sram_ctrl #(
    parameter int unsigned WAIT_CYCLES = 5,
    parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_dq_out,
    input  logic [15:0] sram_dq_in,
    output logic        sram_dq_oe,
    output logic        sram_we_n,
    output logic        sram_oe_n,
    output logic        sram_ce_n
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LO,
        S_HI,
        S_DONE
    } state_e;

    // Terminal count of a half-word phase.
    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        op_write_q, op_write_d;
    logic [16:0] word_q, word_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] read_data_q, read_data_d;

    logic        req;
    logic        phase_last;
    logic [16:0] word_idx;

    assign req        = rd_en | wr_en;
    assign phase_last = (cnt_q == LAST_CNT);
    // Byte offset from the SRAM window, turned into a 32-bit word index. The
    // byte lane bits drop out and anything outside the window simply wraps.
    assign word_idx   = 17'((address - BASE_ADDR) >> 2);

    assign read_data  = read_data_q;

    // State register and latched request; everything returns to IDLE on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            op_write_q  <= 1'b0;
            word_q      <= '0;
            wdata_q     <= '0;
            read_data_q <= '0;
        end else begin
            // NOTE: registers take non-blocking assignments so every flop
            // samples the pre-edge value of its neighbours.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_write_q  <= op_write_d;
            word_q      <= word_d;
            wdata_q     <= wdata_d;
            read_data_q <= read_data_d;
        end
    end

    // Next-state logic: request capture, phase counting and read capture.
    always_comb begin
        // NOTE: every signal gets a hold default before the case so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_write_d  = op_write_q;
        word_d      = word_q;
        wdata_d     = wdata_q;
        read_data_d = read_data_q;

        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    // A simultaneous load and store resolves as a store.
                    op_write_d = wr_en;
                    word_d     = word_idx;
                    wdata_d    = write_data;
                    cnt_d      = '0;
                    state_d    = S_LO;
                end
            end
            S_LO: begin
                if (phase_last) begin
                    if (!op_write_q) begin
                        read_data_d[15:0] = sram_dq_in;
                    end
                    cnt_d   = '0;
                    state_d = S_HI;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_HI: begin
                if (phase_last) begin
                    if (!op_write_q) begin
                        read_data_d[31:16] = sram_dq_in;
                    end
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_DONE: begin
                // Requests seen here belong to the access just finishing.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // SRAM strobes, address/data buses and the pipeline ready flag.
    always_comb begin
        ready       = 1'b0;
        sram_addr   = '0;
        sram_dq_out = '0;
        sram_dq_oe  = 1'b0;
        sram_we_n   = 1'b1;
        sram_oe_n   = 1'b1;
        sram_ce_n   = 1'b1;

        unique case (state_q)
            S_IDLE: begin
                ready = !req;
            end
            S_LO, S_HI: begin
                sram_ce_n = 1'b0;
                sram_addr = {word_q, (state_q == S_HI)};
                if (op_write_q) begin
                    sram_dq_oe  = 1'b1;
                    sram_dq_out = (state_q == S_HI) ? wdata_q[31:16] : wdata_q[15:0];
                    // Release WE one cycle early so data holds past the pulse.
                    sram_we_n   = phase_last;
                end else begin
                    sram_oe_n = 1'b0;
                end
            end
            S_DONE: begin
                ready = 1'b1;
            end
            default: begin
                ready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// tb_mem_sram_ctrl: drives directed and random load/store traffic into
// mem_sram_ctrl, with a behavioural half-word SRAM on the bus and a word-level
// reference memory predicting every load result.
module tb_mem_sram_ctrl;

    localparam int          W    = 5;
    localparam logic [31:0] BASE = 32'd1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic [15:0] sram_dq_in;
    logic        sram_dq_oe;
    logic        sram_we_n;
    logic        sram_oe_n;
    logic        sram_ce_n;

    int n_cmp = 0;
    int n_bad = 0;

    // Expected value of read_data (changes only on completed reads and reset).
    logic [31:0] exp_rd;

    always #5 clk = ~clk;

    mem_sram_ctrl #(
        .WAIT_CYCLES(W),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .ready      (ready),
        .sram_addr  (sram_addr),
        .sram_dq_out(sram_dq_out),
        .sram_dq_in (sram_dq_in),
        .sram_dq_oe (sram_dq_oe),
        .sram_we_n  (sram_we_n),
        .sram_oe_n  (sram_oe_n),
        .sram_ce_n  (sram_ce_n)
    );

    // ---------------- behavioural SRAM device ----------------
    logic [15:0] dev_val     [0:262143];
    bit          dev_written [0:262143];

    // Power-on contents of the SRAM model; half-words 2 and 3 hold a known word.
    function automatic logic [15:0] init_hw(input logic [17:0] a);
        logic [31:0] h;
        if (a == 18'd2) return 16'hBEEF;
        if (a == 18'd3) return 16'hDEAD;
        h = {14'd0, a} * 32'd40503;
        return h[15:0] ^ 16'h5A5A;
    endfunction

    function automatic logic [15:0] dev_read(input logic [17:0] a);
        return dev_written[a] ? dev_val[a] : init_hw(a);
    endfunction

    assign sram_dq_in = (!sram_ce_n && !sram_oe_n) ? dev_read(sram_addr) : 16'hA5A5;

    always @(posedge clk) begin
        if (!sram_ce_n && !sram_we_n && sram_dq_oe) begin
            dev_val[sram_addr]     <= sram_dq_out;
            dev_written[sram_addr] <= 1'b1;
        end
    end

    // ---------------- word-level reference memory ----------------
    logic [31:0] ref_mem [int unsigned];

    function automatic int unsigned ref_index(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return (off / 32'd4) % 32'd131072;
    endfunction

    function automatic logic [31:0] ref_read(input int unsigned idx);
        if (ref_mem.exists(idx)) return ref_mem[idx];
        return {init_hw(18'(2 * idx + 1)), init_hw(18'(2 * idx))};
    endfunction

    // ---------------- access driver with inline checks ----------------
    // Starts at posedge+1 of the request cycle and returns at posedge+1 of the
    // cycle after DONE, with the request lines still asserted.
    task automatic do_access(input logic wr, input logic rd, input logic [31:0] addr,
                             input logic [31:0] wdata, input string name);
        int          stall;
        int          act;
        int          bad_addr;
        int          bad_ctl;
        int          bad_data;
        logic        got_done;
        logic        plast;
        int unsigned idx;
        logic [17:0] exp_a;
        logic [15:0] lo_hw;
        logic [15:0] hi_hw;

        idx        = ref_index(addr);
        wr_en      = wr;
        rd_en      = rd;
        address    = addr;
        write_data = wdata;
        stall      = 0;
        act        = 0;
        bad_addr   = 0;
        bad_ctl    = 0;
        bad_data   = 0;
        got_done   = 1'b0;

        for (int cyc = 0; cyc < 100 && !got_done; cyc++) begin
            @(negedge clk);
            if (ready) begin
                got_done = 1'b1;
                n_cmp++;
                if (sram_ce_n !== 1'b1 || sram_addr !== 18'd0 || sram_we_n !== 1'b1) begin
                    n_bad++;
                    $display("FAIL %s done_bus: ce_n=%b addr=%0d we_n=%b, required ce_n=1 addr=0 we_n=1",
                             name, sram_ce_n, sram_addr, sram_we_n);
                end
            end else begin
                stall++;
                if (!sram_ce_n) begin
                    exp_a = {idx[16:0], (act >= W)};
                    plast = ((act % W) == W - 1);
                    if (sram_addr !== exp_a) bad_addr++;
                    if (wr) begin
                        if (sram_dq_oe !== 1'b1 || sram_oe_n !== 1'b1 || sram_we_n !== plast) bad_ctl++;
                        if (sram_dq_out !== ((act < W) ? wdata[15:0] : wdata[31:16])) bad_data++;
                    end else begin
                        if (sram_dq_oe !== 1'b0 || sram_oe_n !== 1'b0 || sram_we_n !== 1'b1) bad_ctl++;
                    end
                    act++;
                end
            end
            @(posedge clk);
            #1;
        end

        n_cmp++;
        if (!got_done) begin
            n_bad++;
            $display("FAIL %s timeout: no ready within 100 cycles, required ready after %0d", name, 2 * W + 1);
        end
        n_cmp++;
        if (stall != 2 * W + 1) begin
            n_bad++;
            $display("FAIL %s stall: %0d cycles with ready=0, required %0d", name, stall, 2 * W + 1);
        end
        n_cmp++;
        if (act != 2 * W) begin
            n_bad++;
            $display("FAIL %s active: %0d cycles with ce_n=0, required %0d", name, act, 2 * W);
        end
        n_cmp++;
        if (bad_addr != 0) begin
            n_bad++;
            $display("FAIL %s sram_addr: %0d wrong cycles, required 0 (word %0d)", name, bad_addr, idx);
        end
        n_cmp++;
        if (bad_ctl != 0) begin
            n_bad++;
            $display("FAIL %s strobes: %0d wrong cycles, required 0 (write=%b)", name, bad_ctl, wr);
        end

        if (wr) begin
            ref_mem[idx] = wdata;
            n_cmp++;
            if (bad_data != 0) begin
                n_bad++;
                $display("FAIL %s dq_out: %0d wrong cycles, required 0", name, bad_data);
            end
            lo_hw = dev_read({idx[16:0], 1'b0});
            hi_hw = dev_read({idx[16:0], 1'b1});
            n_cmp++;
            if ({hi_hw, lo_hw} !== wdata) begin
                n_bad++;
                $display("FAIL %s sram_content: got %h, required %h", name, {hi_hw, lo_hw}, wdata);
            end
        end else begin
            exp_rd = ref_read(idx);
        end

        n_cmp++;
        if (read_data !== exp_rd) begin
            n_bad++;
            $display("FAIL %s read_data: got %h, required %h", name, read_data, exp_rd);
        end
    endtask

    task automatic release_bus(input int gap);
        wr_en = 1'b0;
        rd_en = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst        = 1'b1;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        address    = '0;
        write_data = '0;
        #2;
        n_cmp++;
        if (read_data !== 32'd0) begin
            n_bad++;
            $display("FAIL reset read_data: got %h, required 0", read_data);
        end
        n_cmp++;
        if (ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset ready: got %b, required 1", ready);
        end
        n_cmp++;
        if (sram_addr !== 18'd0 || sram_dq_out !== 16'd0 || sram_dq_oe !== 1'b0) begin
            n_bad++;
            $display("FAIL reset bus: addr=%0d dq_out=%h dq_oe=%b, required 0 0 0",
                     sram_addr, sram_dq_out, sram_dq_oe);
        end
        n_cmp++;
        if (sram_we_n !== 1'b1 || sram_oe_n !== 1'b1 || sram_ce_n !== 1'b1) begin
            n_bad++;
            $display("FAIL reset strobes: we_n=%b oe_n=%b ce_n=%b, required 1 1 1",
                     sram_we_n, sram_oe_n, sram_ce_n);
        end
        // A request under reset must not start anything.
        rd_en = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (ready !== 1'b0 || sram_ce_n !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_hold: ready=%b ce_n=%b, required ready=0 ce_n=1", ready, sram_ce_n);
        end
        rd_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        exp_rd = 32'd0;
    endtask

    task automatic test_idle();
        int bad;
        bad   = 0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (ready !== 1'b1 || sram_ce_n !== 1'b1 || sram_we_n !== 1'b1 || sram_oe_n !== 1'b1
                || sram_dq_oe !== 1'b0 || sram_addr !== 18'd0) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_bad++;
            $display("FAIL idle: %0d of 20 cycles showed activity, required 0", bad);
        end
        n_cmp++;
        if (read_data !== exp_rd) begin
            n_bad++;
            $display("FAIL idle read_data: got %h, required %h", read_data, exp_rd);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_read_directed();
        do_access(1'b0, 1'b1, 32'd1028, 32'd0, "read_1028");
        n_cmp++;
        if (read_data !== 32'hDEADBEEF) begin
            n_bad++;
            $display("FAIL read_1028 value: got %h, required deadbeef", read_data);
        end
        release_bus(1);
    endtask

    task automatic test_write_directed();
        do_access(1'b1, 1'b0, 32'd1024, 32'h12345678, "write_1024");
        release_bus(2);
    endtask

    task automatic test_back_to_back();
        do_access(1'b0, 1'b1, 32'd1024, 32'd0, "b2b_first");
        do_access(1'b0, 1'b1, 32'd1032, 32'd0, "b2b_second");
        release_bus(1);
    endtask

    task automatic test_simultaneous();
        logic [31:0] d;
        d = $urandom;
        do_access(1'b1, 1'b1, 32'd1040, d, "both_write");
        release_bus(1);
        do_access(1'b0, 1'b1, 32'd1040, 32'd0, "both_readback");
        release_bus(1);
    endtask

    task automatic test_wrap();
        // 2^17 words past the base aliases back onto word 3.
        do_access(1'b1, 1'b0, BASE + 32'd524300, 32'hCAFEF00D, "wrap_write");
        release_bus(1);
        do_access(1'b0, 1'b1, BASE + 32'd12 + 32'd3, 32'd0, "wrap_read");
        release_bus(1);
    endtask

    task automatic test_abort();
        logic [31:0] a;
        logic [31:0] w;
        a          = BASE + 32'd200;
        w          = ref_read(ref_index(a));
        wr_en      = 1'b0;
        rd_en      = 1'b1;
        address    = a;
        write_data = '0;
        repeat (1 + W + 2) @(posedge clk);
        #1;
        n_cmp++;
        if (read_data[15:0] !== w[15:0]) begin
            n_bad++;
            $display("FAIL abort low_capture: got %h, required %h", read_data[15:0], w[15:0]);
        end
        #1;
        rst   = 1'b1;
        rd_en = 1'b0;
        #1;
        exp_rd = 32'd0;
        n_cmp++;
        if (read_data !== 32'd0 || sram_ce_n !== 1'b1 || ready !== 1'b1 || sram_addr !== 18'd0) begin
            n_bad++;
            $display("FAIL abort: read_data=%h ce_n=%b ready=%b addr=%0d, required 0 1 1 0",
                     read_data, sram_ce_n, ready, sram_addr);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        do_access(1'b0, 1'b1, a, 32'd0, "abort_retry");
        release_bus(1);
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] d;
        int          op;
        for (int i = 0; i < 30; i++) begin
            op = $urandom_range(0, 2);
            if ($urandom_range(0, 5) == 0) a = $urandom;
            else a = BASE + 32'($urandom_range(0, 63)) * 32'd4 + 32'($urandom_range(0, 3));
            d = $urandom;
            case (op)
                0:       do_access(1'b0, 1'b1, a, d, "rand_read");
                1:       do_access(1'b1, 1'b0, a, d, "rand_write");
                default: do_access(1'b1, 1'b1, a, d, "rand_both");
            endcase
            release_bus($urandom_range(0, 2));
        end
    endtask

    initial begin
        exp_rd = 32'd0;
        test_reset();
        test_idle();
        test_read_directed();
        test_write_directed();
        test_back_to_back();
        test_simultaneous();
        test_wrap();
        test_abort();
        test_random();
        test_idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_sram_ctrl.md
MEM_SRAM_CTRL -- requirements
Module: mem_sram_ctrl

Interface
REQ-001 Parameter WAIT_CYCLES, default 5: clock cycles per 16-bit SRAM half-word access phase; legal range 2..15.
REQ-002 Parameter BASE_ADDR, default 32'd1024: CPU byte address mapped to SRAM word 0.
REQ-003 clk  input  1: single clock; all state on rising edge.
REQ-004 rst  input  1: asynchronous, active-high reset.
REQ-005 wr_en  input  1: MEM-stage store request; held stable by the pipeline while ready=0.
REQ-006 rd_en  input  1: MEM-stage load request; held stable while ready=0.
REQ-007 address  input  32: CPU byte address (ALU result from EXE/MEM).
REQ-008 write_data  input  32: store value.
REQ-009 read_data  output  32: load result, registered; feeds the MEM/WB register memory-result input.
REQ-010 ready  output  1: access complete or no access pending; 0 freezes the pipeline.
REQ-011 sram_addr  output  18: SRAM half-word address.
REQ-012 sram_dq_out  output  16: SRAM write data.
REQ-013 sram_dq_in  input  16: SRAM read data.
REQ-014 sram_dq_oe  output  1: 1 = controller drives the SRAM data bus.
REQ-015 sram_we_n  output  1: SRAM write enable, active-low.
REQ-016 sram_oe_n  output  1: SRAM output enable, active-low.
REQ-017 sram_ce_n  output  1: SRAM chip enable, active-low.

Function
REQ-018 The FSM SHALL have states IDLE, LO, HI, DONE and a 4-bit phase counter cnt.
REQ-019 In IDLE with rd_en|wr_en=1, the FSM SHALL latch op (write if wr_en=1, else read), address and write_data, clear cnt, and go to LO at the next edge; otherwise it remains in IDLE.
REQ-020 If wr_en and rd_en are both 1, the write SHALL take priority and read_data SHALL be left unchanged.
REQ-021 Word index SHALL be (address - BASE_ADDR) >> 2, truncated to 17 bits; address[1:0] is ignored; out-of-range addresses wrap silently with no error.
REQ-022 sram_addr SHALL be {word_index, 1'b0} in LO and {word_index, 1'b1} in HI, and 0 in IDLE and DONE.
REQ-023 LO and HI SHALL each last exactly WAIT_CYCLES cycles; cnt increments each cycle and the state advances when cnt = WAIT_CYCLES-1 (LO->HI with cnt cleared, HI->DONE).
REQ-024 DONE SHALL last one cycle and then return to IDLE unconditionally.
REQ-025 ready SHALL be combinational: 1 in DONE, 1 in IDLE when rd_en|wr_en=0, and 0 otherwise.
REQ-026 Total latency SHALL be 2*WAIT_CYCLES+1 cycles with ready=0, counted from the request cycle, followed by exactly one DONE cycle with ready=1.
REQ-027 sram_ce_n SHALL be 0 in LO/HI and 1 in IDLE/DONE.
REQ-028 Write phase: sram_dq_oe=1, sram_oe_n=1, and sram_dq_out is write_data[15:0] in LO and write_data[31:16] in HI; sram_we_n=0 for cnt < WAIT_CYCLES-1 and 1 on the last cycle of each phase.
REQ-029 Read phase: sram_dq_oe=0, sram_we_n=1, sram_oe_n=0.
REQ-030 On the last LO cycle, sram_dq_in SHALL be captured into read_data[15:0]; on the last HI cycle, into read_data[31:16].
REQ-031 read_data SHALL be stable from DONE until the next read completes.
REQ-032 Requests arriving in LO, HI or DONE SHALL be ignored; a request still asserted in the cycle after DONE is a new access.

Reset
REQ-033 On rst=1, asynchronously: state=IDLE, cnt=0, read_data=0, sram_addr=0, sram_dq_out=0, sram_dq_oe=0, sram_we_n=1, sram_oe_n=1, sram_ce_n=1.
REQ-034 A reset asserted mid-access SHALL abort the access with no partial read_data update surviving; ready then follows REQ-025 from IDLE.

Verification
REQ-035 Read: WAIT_CYCLES=5, address=1028, model SRAM half-word 2=16'hBEEF and half-word 3=16'hDEAD, rd_en=1 -> ready=0 for 11 cycles, sram_addr=2 then 3, ready=1 in cycle 12, read_data=32'hDEADBEEF.
REQ-036 Write: address=1024, write_data=32'h12345678, wr_en=1 -> sram_addr 0 carries 16'h5678 and sram_addr 1 carries 16'h1234, sram_we_n low for 4 of 5 cycles per phase, ready=1 at cycle 12.
REQ-037 Idle: rd_en=wr_en=0 for 20 cycles -> ready=1 continuously, sram_ce_n=1, no SRAM activity.
REQ-038 Simultaneous: wr_en=rd_en=1 -> write performed, read_data unchanged.
REQ-039 Abort: rst pulsed during HI cycle 3 of a read -> immediately IDLE, read_data=0, sram_ce_n=1; a subsequent read completes normally.
REQ-040 Back-to-back: a read at 1024 followed immediately by a read at 1032 -> two distinct 11-cycle stalls, each with a one-cycle DONE, and correct data for both.
